// File: rtl/seg_codes_pkg.sv
// Shared digit codes, formatter FSM states and constant helpers for the
// seven-segment display path (formatter and decoder).
package seg_codes_pkg;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_ERR   = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_FORMAT
    } fmt_state_e;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter: one bit per clock,
// WIDTH shifts after start, then a one-cycle valid pulse with bcd held stable.
module bin2bcd_seq #(
    parameter int WIDTH      = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIDTH-1:0]        bin,
    output logic                    busy,
    output logic [NUM_DIGITS*4-1:0] bcd,
    output logic                    valid
);

    localparam int BCD_W = NUM_DIGITS * 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    always_comb begin
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        adj     = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        if (start) begin
            bin_d  = bin;
            bcd_d  = '0;
            cnt_d  = CNT_W'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {adj[BCD_W-2:0], bin_q[WIDTH-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        bin_q <= bin_d;
        bcd_q <= bcd_d;
    end

    assign busy  = busy_q;
    assign bcd   = bcd_q;
    assign valid = valid_q;

endmodule

// File: rtl/seg_display_formatter.sv
// Converts a signed value (or error flag) to per-digit display codes and
// scans them onto one shared seven-segment decoder with a one-hot select.
module seg_display_formatter
    import seg_codes_pkg::*;
#(
    parameter int WIDTH      = 14,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] value_in,
    input  logic                    error_in,
    input  logic                    load,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   digit_sel
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [31:0] POS_MAX = pow10(NUM_DIGITS) - 32'd1;
    localparam logic [31:0] NEG_MAX = pow10(NUM_DIGITS - 1) - 32'd1;

    typedef logic [NUM_DIGITS-1:0][3:0] disp_t;

    fmt_state_e             state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   sign_q, sign_d;
    logic                   err_q, err_d;
    logic [WIDTH-1:0]       mag_q, mag_d;
    disp_t                  disp_q, disp_d, shadow;
    logic [CNT_W-1:0]       scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DIGITS-1:0]  sel_q, sel_d;
    logic [3:0]             code_q, code_d;

    logic [WIDTH-1:0]          mag_in;
    logic                      eng_start, eng_busy, eng_valid;
    logic [NUM_DIGITS*4-1:0]   eng_bcd;
    logic [31:0]               mag_ext;
    logic                      ovf, lead;
    logic                      scan_wrap;

    // Two's complement magnitude as unsigned: the most negative value maps to 2^(WIDTH-1).
    assign mag_in    = value_in[WIDTH-1] ? WIDTH'(-value_in) : WIDTH'(value_in);
    assign eng_start = load && (state_q == ST_IDLE);
    assign mag_ext   = 32'(mag_q);

    bin2bcd_seq #(
        .WIDTH     (WIDTH),
        .NUM_DIGITS(NUM_DIGITS)
    ) u_bin2bcd (
        .clk  (clk),
        .rst_n(rst_n),
        .start(eng_start),
        .bin  (mag_in),
        .busy (eng_busy),
        .bcd  (eng_bcd),
        .valid(eng_valid)
    );

    always_comb begin
        ovf    = sign_q ? (mag_ext > NEG_MAX) : (mag_ext > POS_MAX);
        lead   = 1'b1;
        shadow = {NUM_DIGITS{CODE_BLANK}};
        if (err_q || ovf) begin
            shadow[NUM_DIGITS-1] = CODE_ERR;
        end else begin
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                if (sign_q && (i == NUM_DIGITS - 1)) begin
                    shadow[i] = CODE_DASH;
                end else if (lead && (i != 0) && (eng_bcd[i*4 +: 4] == 4'd0)) begin
                    shadow[i] = CODE_BLANK;
                end else begin
                    shadow[i] = eng_bcd[i*4 +: 4];
                    lead      = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sign_d  = sign_q;
        err_d   = err_q;
        mag_d   = mag_q;
        disp_d  = disp_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    sign_d  = value_in[WIDTH-1];
                    err_d   = error_in;
                    mag_d   = mag_in;
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (eng_valid && !eng_busy) begin
                    state_d = ST_FORMAT;
                end
            end
            ST_FORMAT: begin
                disp_d  = shadow;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scanner free-runs; select and code are registered from next-state so they move together.
    always_comb begin
        scan_wrap  = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (scan_wrap) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        sel_d        = '0;
        sel_d[idx_d] = 1'b1;
        code_d       = disp_d[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            disp_q     <= {NUM_DIGITS{CODE_BLANK}};
            scan_cnt_q <= '0;
            idx_q      <= '0;
            sel_q      <= NUM_DIGITS'(1);
            code_q     <= CODE_BLANK;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            disp_q     <= disp_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            code_q     <= code_d;
        end
    end

    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        err_q  <= err_d;
        mag_q  <= mag_d;
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign digit_code = code_q;
    assign digit_sel  = sel_q;

endmodule

// File: tb/tb_seg_display_formatter.sv
// Scoreboard bench for seg_display_formatter: loads push expected digits and
// done time; a monitor pops and checks them when done pulses.
module tb_seg_display_formatter;

    localparam int W  = 14;
    localparam int N  = 4;
    localparam int SD = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic signed [W-1:0]   value_in = '0;
    logic                  error_in = 1'b0;
    logic                  load = 1'b0;
    logic                  busy, done;
    logic [3:0]            digit_code;
    logic [N-1:0]          digit_sel;

    seg_display_formatter #(
        .WIDTH     (W),
        .NUM_DIGITS(N),
        .SCAN_DIV  (SD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value_in  (value_in),
        .error_in  (error_in),
        .load      (load),
        .busy      (busy),
        .done      (done),
        .digit_code(digit_code),
        .digit_sel (digit_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] disp;
        int          t_done;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Samples 13 consecutive negedges so every digit is selected at least once.
    task automatic read_disp(output logic [15:0] got, output bit bad_sel);
        got     = 'x;
        bad_sel = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (!$onehot(digit_sel)) bad_sel = 1'b1;
            for (int j = 0; j < N; j++) begin
                if (digit_sel[j]) got[j*4 +: 4] = digit_code;
            end
            if (k < 12) @(negedge clk);
        end
    endtask

    initial begin : monitor
        int          t;
        exp_t        e;
        logic [15:0] got;
        bit          bad_sel;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                t = cyc;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: done pulse at cycle %0d with nothing expected", t);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", t, e.t_done);
                    read_disp(got, bad_sel);
                    check("display", {16'd0, got}, {16'd0, e.disp});
                    check("sel_onehot", {31'd0, bad_sel}, 32'd0);
                end
            end
        end
    end

    task automatic load_now(input int v, input bit err, input logic [15:0] exp, input bit push);
        value_in = W'(v);
        error_in = err;
        load     = 1'b1;
        if (push) sb.push_back('{disp: exp, t_done: cyc + 17});
        @(posedge clk);
        #1;
        load     = 1'b0;
        error_in = 1'b0;
        if (push) check("busy_after_load", {31'd0, busy}, 32'd1);
    endtask

    task automatic do_load(input int v, input bit err, input logic [15:0] exp);
        @(negedge clk);
        load_now(v, err, exp, 1'b1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) check("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        int          t0;
        int          k;
        logic [15:0] got;
        bit          bad_sel;

        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Asynchronous reset asserted mid-cycle
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_sel", {28'd0, digit_sel}, 32'h1);
        check("rst_code", {28'd0, digit_code}, 32'hF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("scan_hold", {28'd0, digit_sel}, 32'h1);
        @(negedge clk);
        check("scan_adv", {28'd0, digit_sel}, 32'h2);
        repeat (11) @(negedge clk);
        check("scan_last", {28'd0, digit_sel}, 32'h8);
        @(negedge clk);
        check("scan_wrap", {28'd0, digit_sel}, 32'h1);

        // Basic conversion with explicit busy/done timing
        do_load(305, 1'b0, 16'hF305);
        t0 = cyc;
        while (cyc < t0 + 15) @(negedge clk);
        check("busy_last_cycle", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("busy_clear", {31'd0, busy}, 32'd0);
        check("done_pulse", {31'd0, done}, 32'd1);
        wait_idle();

        do_load(0, 1'b0, 16'hFFF0);     wait_idle();
        do_load(-42, 1'b0, 16'hAF42);   wait_idle();
        do_load(-999, 1'b0, 16'hA999);  wait_idle();
        do_load(-8192, 1'b0, 16'hEFFF); wait_idle();
        do_load(-1000, 1'b0, 16'hEFFF); wait_idle();
        do_load(8191, 1'b0, 16'h8191);  wait_idle();
        do_load(5, 1'b1, 16'hEFFF);     wait_idle();

        // Load while busy is dropped; load on the done cycle is accepted
        do_load(123, 1'b0, 16'hF123);
        repeat (3) @(negedge clk);
        load_now(456, 1'b0, 16'h0000, 1'b0);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) check("done_wait_timeout", 32'd1, 32'd0);
        load_now(456, 1'b0, 16'hF456, 1'b1);
        wait_idle();
        repeat (14) @(negedge clk);

        // Reset during conversion aborts and blanks the display
        do_load(77, 1'b0, 16'hFFFF);
        t0 = cyc;
        while (cyc < t0 + 8) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        read_disp(got, bad_sel);
        check("abort_blank", {16'd0, got}, 32'h0000FFFF);

        do_load(9, 1'b0, 16'hFFF9);
        wait_idle();
        repeat (15) @(negedge clk);

        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
